// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bus of the 3x3 window generator.
// The generator connects through the slave modport; the pixel source and
// window consumer side (or a testbench) uses the master modport.
interface window_gen_3x3_if #(
  parameter int DW = 8
);

  logic [DW-1:0]   i_pixel_data;
  logic            i_pixel_valid;
  logic            o_in_ready;
  logic            i_rd_en;
  logic [9*DW-1:0] o_window;
  logic            o_window_valid;
  logic            o_line_done;

  modport slave (
    input  i_pixel_data,
    input  i_pixel_valid,
    input  i_rd_en,
    output o_in_ready,
    output o_window,
    output o_window_valid,
    output o_line_done
  );

  modport master (
    output i_pixel_data,
    output i_pixel_valid,
    output i_rd_en,
    input  o_in_ready,
    input  o_window,
    input  o_window_valid,
    input  o_line_done
  );

endinterface

// File: rtl/window_gen_3x3.sv
// 3x3 window generator for the convolution front-end.
// Raster pixels are written round-robin into four line stores. Once three
// full lines are held, windows are read from the three oldest lines, one
// column step per downstream enable. Finishing a line of windows releases
// the oldest store back to the writer and pulses o_line_done.
module window_gen_3x3 #(
  parameter int IMG_W  = 28,
  parameter int DW     = 8,
  parameter int NLINES = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int SW = $clog2(NLINES);
  localparam int FW = $clog2(NLINES * IMG_W + 1);

  localparam logic [FW-1:0] FILL_FULL   = FW'(NLINES * IMG_W);
  localparam logic [FW-1:0] FILL_READ   = FW'(3 * IMG_W);
  localparam logic [FW-1:0] FILL_LINE   = FW'(IMG_W);
  localparam logic [FW-1:0] FILL_ONE    = FW'(1);
  localparam logic [CW-1:0] COL_ONE     = CW'(1);
  localparam logic [CW-1:0] COL_LAST_WR = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LAST_RD = CW'(IMG_W - 3);
  localparam logic [SW-1:0] SEL_ONE     = SW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Line stores; contents are intentionally not cleared by reset.
  logic [DW-1:0]   line_mem_q [NLINES][IMG_W];

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_col_q, wr_col_d;
  logic [SW-1:0]   wr_sel_q, wr_sel_d;
  logic [CW-1:0]   rd_col_q, rd_col_d;
  logic [SW-1:0]   rd_sel_q, rd_sel_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [9*DW-1:0] window_q, window_d;
  logic            window_valid_q, window_valid_d;
  logic            line_done_q, line_done_d;

  logic            in_ready_s;
  logic            accept_s;
  logic            fire_s;
  logic            row_done_s;
  logic [9*DW-1:0] window_rd_s;

  // Handshake qualifiers: a free slot exists unless all four lines are held.
  always_comb begin
    in_ready_s = (fill_q != FILL_FULL);
    accept_s   = bus.i_pixel_valid & in_ready_s;
    fire_s     = (state_q == ST_READ) & bus.i_rd_en;
    row_done_s = fire_s & (rd_col_q == COL_LAST_RD);
  end

  // Write pointer: advance per accepted pixel, move to next store at line end.
  always_comb begin
    wr_col_d = wr_col_q;
    wr_sel_d = wr_sel_q;
    if (accept_s) begin
      if (wr_col_q == COL_LAST_WR) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + SEL_ONE;
      end else begin
        wr_col_d = wr_col_q + COL_ONE;
      end
    end else begin
      wr_col_d = wr_col_q;
    end
  end

  // Read pointer: one column per window, release oldest line after the last column.
  always_comb begin
    rd_col_d = rd_col_q;
    rd_sel_d = rd_sel_q;
    if (row_done_s) begin
      rd_col_d = '0;
      rd_sel_d = rd_sel_q + SEL_ONE;
    end else if (fire_s) begin
      rd_col_d = rd_col_q + COL_ONE;
    end else begin
      rd_col_d = rd_col_q;
    end
  end

  // Fill count: pixels stored and not yet released with their line.
  always_comb begin
    fill_d = fill_q;
    case ({accept_s, row_done_s})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_LINE;
      2'b11:   fill_d = fill_q + FILL_ONE - FILL_LINE;
      default: fill_d = fill_q;
    endcase
  end

  // Read FSM: wait for three complete lines, then serve one line of windows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_q >= FILL_READ) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (row_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window assembly: oldest line on top, lowest column in the MSBs of each row.
  always_comb begin
    window_rd_s = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        window_rd_s[(8 - (r * 3 + k)) * DW +: DW] =
          line_mem_q[rd_sel_q + SW'(r)][rd_col_q + CW'(k)];
      end
    end
  end

  // Output register inputs: capture a window per fire, otherwise hold it.
  always_comb begin
    window_valid_d = fire_s;
    line_done_d    = row_done_s;
    if (fire_s) begin
      window_d = window_rd_s;
    end else begin
      window_d = window_q;
    end
  end

  // Line store write port, no reset on the storage array.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      line_mem_q[wr_sel_q][wr_col_q] <= bus.i_pixel_data;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      wr_col_q       <= '0;
      wr_sel_q       <= '0;
      rd_col_q       <= '0;
      rd_sel_q       <= '0;
      fill_q         <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      line_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_col_q       <= wr_col_d;
      wr_sel_q       <= wr_sel_d;
      rd_col_q       <= rd_col_d;
      rd_sel_q       <= rd_sel_d;
      fill_q         <= fill_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      line_done_q    <= line_done_d;
    end
  end

  assign bus.o_in_ready     = in_ready_s;
  assign bus.o_window       = window_q;
  assign bus.o_window_valid = window_valid_q;
  assign bus.o_line_done    = line_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3. The reference keeps every accepted
// pixel of the continuous stream in a queue; the window for line group r,
// column c is taken straight from stream positions (r+i)*W + c + j.
module tb_window_gen_3x3;

  localparam int W    = 28;
  localparam int DW   = 8;
  localparam int NWIN = W - 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  window_gen_3x3_if #(.DW(DW)) bus ();

  window_gen_3x3 #(.IMG_W(W), .DW(DW), .NLINES(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  stream[$];
  int          rel;
  int          col;
  int          win_cnt;
  int          ld_cnt;
  logic [71:0] last_win;
  logic [71:0] first_win;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[(8 - (i * 3 + j)) * 8 +: 8] = stream[(r + i) * W + c + j];
      end
    end
    return w;
  endfunction

  task automatic model_clear();
    stream.delete();
    rel      = 0;
    col      = 0;
    win_cnt  = 0;
    ld_cnt   = 0;
    last_win = '0;
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic step(input logic pv, input logic [7:0] pd, input logic rd);
    logic mr;
    logic acc;
    logic ld_exp;
    logic avail;
    int   sz0;
    mr = ((stream.size() - W * rel) != 4 * W);
    chk("in_ready", 72'(bus.o_in_ready), 72'(mr));
    bus.i_pixel_valid = pv;
    bus.i_pixel_data  = pd;
    bus.i_rd_en       = rd;
    acc = pv & mr;
    sz0 = stream.size();
    @(posedge i_clk);
    @(negedge i_clk);
    ld_exp = 1'b0;
    if (bus.o_window_valid === 1'b1) begin
      avail = (((rel + 2) * W + col + 2) < sz0);
      chk("valid_needs_rd", 72'(rd), 72'(1'b1));
      chk("window_avail", 72'(avail), 72'(1'b1));
      if (avail) last_win = exp_win(rel, col);
      win_cnt++;
      if (win_cnt == 1) first_win = bus.o_window;
      col++;
      if (col == NWIN) begin
        col    = 0;
        rel++;
        ld_exp = 1'b1;
      end
    end
    chk("window", bus.o_window, last_win);
    chk("line_done", 72'(bus.o_line_done), 72'(ld_exp));
    if (bus.o_line_done === 1'b1) ld_cnt++;
    if (acc) stream.push_back(pd);
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    bus.i_pixel_valid = 1'b0;
    bus.i_rd_en       = 1'b0;
    bus.i_pixel_data  = 8'h00;
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_clear();
    chk("rst_valid", 72'(bus.o_window_valid), 72'(1'b0));
    chk("rst_line_done", 72'(bus.o_line_done), 72'(1'b0));
    chk("rst_in_ready", 72'(bus.o_in_ready), 72'(1'b1));
    chk("rst_window", bus.o_window, 72'h0);
  endtask

  // rd_mode: 0 = always enabled, 1 = toggling, 2 = never.
  task automatic run(input string tag, input int npix, input int target, input bit rnd,
                     input int pct, input int rd_mode, input bit early, input int budget);
    int         start;
    int         cyc;
    int         sent;
    logic       pv;
    logic       rd;
    logic [7:0] pd;
    bit         done;
    start = stream.size();
    cyc   = 0;
    done  = 1'b0;
    while (!done && cyc < budget) begin
      sent = stream.size() - start;
      pv = (sent < npix) && ($urandom_range(99) < pct);
      pd = rnd ? 8'($urandom) : 8'(stream.size() % 256);
      rd = (rd_mode == 0) ? 1'b1 : ((rd_mode == 1) ? 1'(cyc % 2) : 1'b0);
      step(pv, pd, rd);
      cyc++;
      sent = stream.size() - start;
      done = (win_cnt >= target) && (early || sent >= npix);
    end
    chk({tag, "_timeout"}, 72'(done), 72'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_pixel_valid = 1'b0;
    bus.i_pixel_data  = 8'h00;
    bus.i_rd_en       = 1'b0;
    model_clear();
    @(negedge i_clk);

    // T1: reset for two cycles
    do_reset(2);

    // T2: first three lines, ramp data, downstream always ready
    run("t2", 84, 26, 1'b0, 100, 0, 1'b0, 400);
    chk("t2_first", first_win, 72'h00_01_02_1C_1D_1E_38_39_3A);
    chk("t2_last", last_win, 72'h19_1A_1B_35_36_37_51_52_53);
    chk("t2_windows", 72'(win_cnt), 72'(26));
    chk("t2_line_done_cnt", 72'(ld_cnt), 72'(1));
    repeat (10) step(1'b0, 8'h00, 1'b1);
    chk("t2_idle_windows", 72'(win_cnt), 72'(26));

    // T3: fill all four stores, overflow pixel dropped, then drain one line
    do_reset(1);
    for (int i = 0; i < 113; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("t3_full", 72'(bus.o_in_ready), 72'(1'b0));
    chk("t3_no_windows", 72'(win_cnt), 72'(0));
    run("t3_drain", 0, 26, 1'b1, 100, 0, 1'b0, 200);
    chk("t3_ready_again", 72'(bus.o_in_ready), 72'(1'b1));
    step(1'b1, 8'hA5, 1'b1);
    run("t3_reuse", 55, 78, 1'b1, 100, 0, 1'b0, 600);
    chk("t3_windows", 72'(win_cnt), 72'(78));

    // T4: toggling downstream enable, random data with input gaps
    do_reset(1);
    run("t4", 140, 78, 1'b1, 90, 1, 1'b0, 1500);
    chk("t4_windows", 72'(win_cnt), 72'(78));
    chk("t4_line_done_cnt", 72'(ld_cnt), 72'(3));

    // T5: full 28x28 image streaming
    do_reset(1);
    run("t5", 784, 676, 1'b1, 75, 0, 1'b0, 5000);
    chk("t5_windows", 72'(win_cnt), 72'(676));
    chk("t5_line_done_cnt", 72'(ld_cnt), 72'(26));
    chk("t5_last", last_win, exp_win(25, 25));

    // T6: reset in the middle of the fourth line of windows, then restart
    do_reset(1);
    run("t6_pre", 784, 88, 1'b0, 100, 0, 1'b1, 2000);
    i_rst = 1'b1;
    bus.i_rd_en       = 1'b1;
    bus.i_pixel_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("t6_valid", 72'(bus.o_window_valid), 72'(1'b0));
    chk("t6_line_done", 72'(bus.o_line_done), 72'(1'b0));
    chk("t6_in_ready", 72'(bus.o_in_ready), 72'(1'b1));
    i_rst = 1'b0;
    bus.i_pixel_valid = 1'b0;
    bus.i_rd_en       = 1'b0;
    model_clear();
    run("t6_restart", 84, 26, 1'b0, 100, 0, 1'b0, 400);
    chk("t6_first", first_win, 72'h00_01_02_1C_1D_1E_38_39_3A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
